// File: rtl/rptx_pkg.sv
// Shared report-transmitter definitions, also imported by the pad-side receiver.
// Report width, pad ids, FSM state encoding.
package rptx_pkg;

    localparam int         REPORT_BITS     = 128;
    localparam int         BIT_IDX_W       = $clog2(REPORT_BITS);
    localparam logic [7:0] REPORT_ID_LEFT  = 8'h00;
    localparam logic [7:0] REPORT_ID_RIGHT = 8'h01;

    typedef logic [REPORT_BITS-1:0] report_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_GAP
    } state_e;

endpackage

// File: rtl/rptx_if.sv
// Report handoff into the transmitter: valid/ready, one report per handshake.
// The slave drops tx_ready while its holding register is occupied.
interface rptx_if;

    rptx_pkg::report_t tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/rptx_div.sv
// Half-period tick generator: tick_o high on the CLKDIV-th cycle after a clear or previous tick.
// No backpressure; clr_i restarts the count on the following cycle.
module rptx_div #(
    parameter int CLKDIV = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [7:0] CNT_LAST = 8'(CLKDIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign tick_o = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rptx.sv
// Serialises 128-bit pad reports MSB first on sclk/mosi; first sclk rise CLKDIV+2 cycles after acceptance.
// One held report plus one shifting; tx_ready low while the holding register is full.
module rptx
    import rptx_pkg::*;
#(
    parameter int CLKDIV = 4,
    parameter int GAP    = 16
) (
    input  logic    clk,
    input  logic    resetn,
    rptx_if.slave   tx,
    output logic    busy,
    output logic    sclk,
    output logic    mosi
);

    localparam logic [15:0]          GAP_LAST = (GAP > 0) ? 16'(GAP - 1) : 16'd0;
    localparam logic [BIT_IDX_W-1:0] BIT_LAST = BIT_IDX_W'(REPORT_BITS - 1);

    state_e               state_q;
    report_t              hold_q;
    report_t              shift_q;
    logic                 hold_vld_q;
    logic [BIT_IDX_W-1:0] bit_idx_q;
    logic [15:0]          gap_cnt_q;
    logic                 sclk_q;
    logic                 mosi_q;
    logic                 tick;
    logic                 div_clr;
    logic                 accept;

    // The divider free-runs only in LOW/HIGH; every LOW/HIGH entry follows a tick or IDLE.
    assign div_clr     = (state_q == ST_IDLE) || (state_q == ST_GAP);
    assign accept      = tx.tx_valid && !hold_vld_q;
    assign tx.tx_ready = !hold_vld_q;
    assign busy        = (state_q != ST_IDLE) || hold_vld_q;
    assign sclk        = sclk_q;
    assign mosi        = mosi_q;

    rptx_div #(
        .CLKDIV (CLKDIV)
    ) u_div (
        .clk    (clk),
        .resetn (resetn),
        .clr_i  (div_clr),
        .tick_o (tick)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            shift_q    <= '0;
            hold_vld_q <= 1'b0;
            bit_idx_q  <= '0;
            gap_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            // Pins are retimed one cycle behind the FSM, so sclk and mosi keep their mutual alignment.
            sclk_q <= (state_q == ST_HIGH);
            mosi_q <= ((state_q == ST_LOW) || (state_q == ST_HIGH)) ? shift_q[REPORT_BITS-1] : 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (hold_vld_q) begin
                        shift_q    <= hold_q;
                        hold_vld_q <= 1'b0;
                        bit_idx_q  <= '0;
                        state_q    <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (tick) begin
                        state_q <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (tick) begin
                        if (bit_idx_q != BIT_LAST) begin
                            shift_q   <= {shift_q[REPORT_BITS-2:0], 1'b0};
                            bit_idx_q <= bit_idx_q + 1'b1;
                            state_q   <= ST_LOW;
                        end else if (GAP == 0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            gap_cnt_q <= '0;
                            state_q   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 16'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (accept) begin
                hold_q     <= tx.tx_data;
                hold_vld_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rptx.sv
// Directed bench for rptx: one instance at CLKDIV=4/GAP=16, one at CLKDIV=1/GAP=0.
// A pad-receiver model samples mosi on each sclk rise and latches left/right reports.
module tb_rptx;
    import rptx_pkg::*;

    localparam int CD0 = 4;
    localparam int GP0 = 16;
    localparam int CD1 = 1;
    localparam int GP1 = 0;
    localparam int NR1 = 200;

    localparam logic [127:0] V1 = 128'h0123456789ABCDEF0123456789ABEF00;
    localparam logic [127:0] VA = 128'hA5A50000111122223333444455556600;
    localparam logic [127:0] VB = 128'h5A5A9999888877776666555544443301;
    localparam logic [127:0] VE = 128'hDEADBEEF00000000CAFEF00D12345601;
    localparam logic [127:0] VF = 128'h0F0F0F0F123412349876987655AA5500;
    localparam logic [127:0] VC = 128'hFFFFFFFF0000000077777777AAAAAA01;
    localparam logic [127:0] VD = 128'h13579BDF02468ACE13579BDF02468A00;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic busy0, sclk0, mosi0;
    logic busy1, sclk1, mosi1;

    rptx_if if0 ();
    rptx_if if1 ();

    rptx #(.CLKDIV(CD0), .GAP(GP0)) u0 (
        .clk(clk), .resetn(resetn), .tx(if0), .busy(busy0), .sclk(sclk0), .mosi(mosi0)
    );
    rptx #(.CLKDIV(CD1), .GAP(GP1)) u1 (
        .clk(clk), .resetn(resetn), .tx(if1), .busy(busy1), .sclk(sclk1), .mosi(mosi1)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    int           ecnt   = 0;
    int           nr [2];
    logic         ps [2];
    logic         pm [2];
    logic [127:0] rx [2];
    int           prev_rise [2];
    int           fc [2];
    logic [127:0] frames [2][256];
    int           first_rise [2][256];
    int           last_rise [2][256];
    logic [127:0] ldata, rdata;
    int           l_edge, r_edge;
    logic [127:0] sent1 [NR1];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Receiver model for instance g; the receiver is reset together with the transmitter.
    task automatic sample(input int g, input logic s, input logic m, input int cd);
        if (!resetn) begin
            nr[g] = 0;
            rx[g] = '0;
        end else begin
            if (m !== pm[g]) chk("mosi_change_sclk_low", 128'(s), 128'(1'b0));
            if (s === 1'b1 && ps[g] === 1'b0) begin
                nr[g]++;
                rx[g] = {rx[g][126:0], m};
                if (nr[g] % 128 == 1) first_rise[g][fc[g]] = ecnt;
                else chki("rise_spacing", ecnt - prev_rise[g], 2 * cd);
                prev_rise[g] = ecnt;
                if (nr[g] % 128 == 0) begin
                    frames[g][fc[g]]    = rx[g];
                    last_rise[g][fc[g]] = ecnt;
                    if (g == 0 && rx[g][7:0] == REPORT_ID_LEFT) begin
                        ldata  = rx[g];
                        l_edge = ecnt;
                    end else if (g == 0 && rx[g][7:0] == REPORT_ID_RIGHT) begin
                        rdata  = rx[g];
                        r_edge = ecnt;
                    end
                    if (fc[g] < 255) fc[g]++;
                end
            end
        end
        ps[g] = s;
        pm[g] = m;
    endtask

    // ecnt = number of rising edges so far, observed at the falling edge.
    task automatic step();
        @(negedge clk);
        ecnt++;
        sample(0, sclk0, mosi0, CD0);
        sample(1, sclk1, mosi1, CD1);
    endtask

    task automatic wait_frames(input int g, input int n, input int budget, input string tag);
        int k = 0;
        while (fc[g] < n && k < budget) begin
            step();
            k++;
        end
        chki(tag, fc[g], n);
    endtask

    task automatic wait_idle0(input int budget, output int edge_seen);
        int k = 0;
        while (busy0 !== 1'b0 && k < budget) begin
            step();
            k++;
        end
        chk("idle_timeout", 128'(busy0), 128'(1'b0));
        edge_seen = ecnt;
    endtask

    task automatic send0(input logic [127:0] d, output int acc_edge);
        chk("send_ready", 128'(if0.tx_ready), 128'(1'b1));
        if0.tx_data  = d;
        if0.tx_valid = 1'b1;
        acc_edge     = ecnt + 1;
        step();
        if0.tx_valid = 1'b0;
    endtask

    initial begin
        int acc, base, idle_edge, start, k, n;
        logic pend;
        logic [127:0] cur;

        for (int g = 0; g < 2; g++) begin
            nr[g] = 0; ps[g] = 1'b0; pm[g] = 1'b0; rx[g] = '0; fc[g] = 0; prev_rise[g] = 0;
        end
        ldata = '0; rdata = '0; l_edge = 0; r_edge = 0;
        if0.tx_valid = 1'b0; if0.tx_data = '0;
        if1.tx_valid = 1'b0; if1.tx_data = '0;

        resetn = 1'b0;
        repeat (3) step();
        chk("rst_tx_ready", 128'(if0.tx_ready), 128'(1'b1));
        chk("rst_busy", 128'(busy0), 128'(1'b0));
        chk("rst_sclk", 128'(sclk0), 128'(1'b0));
        chk("rst_mosi", 128'(mosi0), 128'(1'b0));
        chk("rst_busy_u1", 128'(busy1), 128'(1'b0));
        resetn = 1'b1;
        repeat (2) step();

        // Single report
        base = fc[0];
        send0(V1, acc);
        chk("single_ready_low", 128'(if0.tx_ready), 128'(1'b0));
        chk("single_busy", 128'(busy0), 128'(1'b1));
        wait_frames(0, base + 1, 1200, "single_frame_count");
        chk("single_data", frames[0][base], V1);
        chki("single_first_rise", first_rise[0][base] - acc, CD0 + 2);
        chki("single_rises", nr[0], 128);
        wait_idle0(200, idle_edge);
        chki("single_busy_len", idle_edge - acc, 256 * CD0 + GP0 + 1);
        repeat (20) step();
        chki("single_no_trailing", nr[0], 128);

        // Back-to-back left then right
        base = fc[0];
        if0.tx_data = VA; if0.tx_valid = 1'b1;
        step();
        chk("b2b_hold_a", 128'(if0.tx_ready), 128'(1'b0));
        if0.tx_data = VB;
        k = 0;
        while (if0.tx_ready !== 1'b1 && k < 10) begin step(); k++; end
        step();
        if0.tx_valid = 1'b0;
        chk("b2b_hold_b", 128'(if0.tx_ready), 128'(1'b0));
        wait_frames(0, base + 2, 2300, "b2b_frame_count");
        chk("b2b_frame_a", frames[0][base], VA);
        chk("b2b_frame_b", frames[0][base + 1], VB);
        chk("pair_ldata", ldata, VA);
        chk("pair_rdata", rdata, VB);
        chki("pair_order", int'(r_edge > l_edge), 1);
        chki("b2b_gap", first_rise[0][base + 1] - last_rise[0][base], 2 * CD0 + GP0 + 1);
        chki("b2b_period", first_rise[0][base + 1] - first_rise[0][base], 256 * CD0 + GP0 + 1);
        wait_idle0(200, idle_edge);

        // Perturb tx_data while stalled
        base = fc[0];
        if0.tx_data = VE; if0.tx_valid = 1'b1;
        step();
        if0.tx_data = VF;
        k = 0;
        while (if0.tx_ready !== 1'b1 && k < 10) begin step(); k++; end
        step();
        for (int i = 0; i < 40; i++) begin
            if0.tx_data = rnd();
            step();
        end
        chk("stall_ready_low", 128'(if0.tx_ready), 128'(1'b0));
        if0.tx_valid = 1'b0;
        wait_frames(0, base + 2, 2300, "stall_frame_count");
        chk("stall_frame_e", frames[0][base], VE);
        chk("stall_frame_f", frames[0][base + 1], VF);
        wait_idle0(200, idle_edge);
        repeat (10) step();
        chki("stall_no_extra", fc[0], base + 2);

        // Reset at bit 60
        base = fc[0];
        start = nr[0];
        send0(VC, acc);
        k = 0;
        while (nr[0] - start < 60 && k < 1000) begin step(); k++; end
        chki("reset_reached_bit60", nr[0] - start, 60);
        resetn = 1'b0;
        if0.tx_valid = 1'b1; if0.tx_data = rnd();
        step();
        chk("mid_rst_sclk", 128'(sclk0), 128'(1'b0));
        chk("mid_rst_mosi", 128'(mosi0), 128'(1'b0));
        chk("mid_rst_ready", 128'(if0.tx_ready), 128'(1'b1));
        chk("mid_rst_busy", 128'(busy0), 128'(1'b0));
        step();
        chk("rst_ignores_valid", 128'(if0.tx_ready), 128'(1'b1));
        resetn = 1'b1;
        if0.tx_valid = 1'b0;
        repeat (30) step();
        chki("rst_no_trailing", nr[0], 0);
        chki("rst_no_partial", fc[0], base);
        send0(VD, acc);
        wait_frames(0, base + 1, 1200, "post_rst_frame_count");
        chk("post_rst_data", frames[0][base], VD);
        chki("post_rst_first_rise", first_rise[0][base] - acc, CD0 + 2);
        chki("post_rst_rises", nr[0], 128);
        wait_idle0(200, idle_edge);

        // CLKDIV=1, GAP=0, continuous valid
        base = fc[1];
        cur = rnd();
        if1.tx_data = cur; if1.tx_valid = 1'b1;
        pend = if1.tx_ready;
        n = 0; k = 0;
        while (n < NR1 && k < NR1 * 300) begin
            step();
            k++;
            if (pend) begin
                sent1[n] = cur;
                n++;
                cur = rnd();
                if1.tx_data = cur;
            end
            pend = if1.tx_ready;
        end
        if1.tx_valid = 1'b0;
        chki("u1_sent", n, NR1);
        wait_frames(1, base + NR1, 800, "u1_frame_count");
        for (int i = 0; i < NR1; i++) begin
            chk("u1_frame", frames[1][base + i], sent1[i]);
            if (i > 0) chki("u1_period", first_rise[1][base + i] - first_rise[1][base + i - 1], 256 * CD1 + GP1 + 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
